// File: rtl/extract_stream_arbiter.sv
// extract_stream_arbiter
//   Shares the single 64-bit message-extractor input between NUM_PORTS
//   upstream feeds. Arbitration is round-robin, one packet per grant. The
//   grant is held until EOP. Stray beats and over-long packets are kept
//   away from the extractor. The output beat sits in a back-pressurable
//   register stage.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   in_valid/in_startofpacket/
//   in_endofpacket   [NUM_PORTS]    per-port beat qualifiers
//   in_data/in_empty                per-port payload, port p in slice p
//   in_ready         [NUM_PORTS]    per-port accept
//   port_enable      [NUM_PORTS]    disabled ports are never granted/drained
//   out_*                           registered output beat towards extractor
//   out_error                       beat closes or carries a protocol violation
//   out_port                        source port of the output beat
//   out_ready                       extractor accept
//   drop_count                      saturating count of discarded input beats
//   busy                            packet in flight or output beat pending
//   dbg_state                       current FSM state (IDLE/LOCKED/DRAIN)
//
// Handshake: on every interface a beat moves on the rising clk edge where
// valid and ready are both high. valid never depends on ready. Data is
// held by the producer while valid & !ready.
module extract_stream_arbiter #(
    parameter int NUM_PORTS      = 4,
    parameter int IN_WIDTH       = 64,
    parameter int IN_EMPTY_WIDTH = $clog2(IN_WIDTH/8),
    parameter int MAX_BEATS      = 255,
    parameter int PORT_W         = $clog2(NUM_PORTS)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_PORTS-1:0]                in_valid,
    input  logic [NUM_PORTS-1:0]                in_startofpacket,
    input  logic [NUM_PORTS-1:0]                in_endofpacket,
    input  logic [NUM_PORTS*IN_WIDTH-1:0]       in_data,
    input  logic [NUM_PORTS*IN_EMPTY_WIDTH-1:0] in_empty,
    output logic [NUM_PORTS-1:0]                in_ready,
    input  logic [NUM_PORTS-1:0]                port_enable,
    output logic                                out_valid,
    output logic                                out_startofpacket,
    output logic                                out_endofpacket,
    output logic [IN_WIDTH-1:0]                 out_data,
    output logic [IN_EMPTY_WIDTH-1:0]           out_empty,
    output logic                                out_error,
    output logic [PORT_W-1:0]                   out_port,
    input  logic                                out_ready,
    output logic [15:0]                         drop_count,
    output logic                                busy,
    output logic [1:0]                          dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOCKED = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [PORT_W-1:0]    last_grant, lock_port;
    logic [7:0]           beat_cnt;
    logic [8:0]           beat_cnt_inc;
    logic                 can_load;
    logic [NUM_PORTS-1:0] cand, stray, ready_arb;
    logic                 win_found;
    logic [PORT_W-1:0]    winner;
    logic                 grant, load, ld_sop, ld_eop, ld_err, drain_drop;
    logic [PORT_W-1:0]    src;
    logic [16:0]          drop_sum;
    logic [15:0]          drop_nxt;

    assign can_load     = !out_valid || out_ready;
    assign beat_cnt_inc = {1'b0, beat_cnt} + 9'd1;
    assign cand         = in_valid & in_startofpacket & port_enable;

    // Round-robin pick: first candidate at or after last_grant+1, wrapping.
    always_comb begin
        int idx;
        win_found = 1'b0;
        winner    = '0;
        idx       = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = (int'(last_grant) + 1 + i) % NUM_PORTS;
            if (!win_found && cand[idx]) begin
                win_found = 1'b1;
                winner    = PORT_W'(idx);
            end
        end
    end

    // Non-SOP beats on enabled ports that are not carrying the current
    // packet are swallowed so they cannot wedge their source.
    always_comb begin
        stray = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            stray[p] = in_valid[p] & ~in_startofpacket[p] & port_enable[p] &
                       ((state == S_IDLE) || (PORT_W'(p) != lock_port));
        end
    end

    always_comb begin
        state_nxt  = state;
        ready_arb  = '0;
        grant      = 1'b0;
        load       = 1'b0;
        src        = lock_port;
        ld_sop     = 1'b0;
        ld_eop     = 1'b0;
        ld_err     = 1'b0;
        drain_drop = 1'b0;
        case (state)
            S_IDLE: begin
                if (win_found && can_load) begin
                    grant             = 1'b1;
                    load              = 1'b1;
                    src               = winner;
                    ready_arb[winner] = 1'b1;
                    ld_sop            = 1'b1;
                    ld_eop            = in_endofpacket[winner];
                    if (!in_endofpacket[winner])
                        state_nxt = S_LOCKED;
                end
            end
            S_LOCKED: begin
                ready_arb[lock_port] = can_load;
                if (in_valid[lock_port] && can_load) begin
                    load   = 1'b1;
                    // A repeated SOP mid-packet is forwarded as a flagged body beat.
                    ld_err = in_startofpacket[lock_port];
                    if (in_endofpacket[lock_port]) begin
                        ld_eop    = 1'b1;
                        state_nxt = S_IDLE;
                    end else if (beat_cnt_inc == 9'(MAX_BEATS)) begin
                        // Runaway packet: close it towards the extractor, drain the rest.
                        ld_eop    = 1'b1;
                        ld_err    = 1'b1;
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                ready_arb[lock_port] = 1'b1;
                if (in_valid[lock_port]) begin
                    drain_drop = 1'b1;
                    if (in_endofpacket[lock_port])
                        state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Nothing is accepted while reset is held, so no beat is half-consumed.
    assign in_ready = reset ? '0 : (ready_arb | stray);

    always_comb begin
        drop_sum = {1'b0, drop_count} + 17'(drain_drop);
        for (int p = 0; p < NUM_PORTS; p++)
            drop_sum = drop_sum + 17'(stray[p]);
        drop_nxt = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= S_IDLE;
            last_grant        <= PORT_W'(NUM_PORTS - 1);
            lock_port         <= '0;
            beat_cnt          <= '0;
            drop_count        <= '0;
            out_valid         <= 1'b0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
            out_data          <= '0;
            out_empty         <= '0;
            out_error         <= 1'b0;
            out_port          <= '0;
        end else begin
            state      <= state_nxt;
            drop_count <= drop_nxt;
            if (grant) begin
                last_grant <= winner;
                lock_port  <= winner;
                beat_cnt   <= 8'd1;
            end else if (load) begin
                beat_cnt <= beat_cnt_inc[7:0];
            end
            if (load) begin
                out_valid         <= 1'b1;
                out_startofpacket <= ld_sop;
                out_endofpacket   <= ld_eop;
                out_error         <= ld_err;
                out_data          <= in_data[int'(src)*IN_WIDTH +: IN_WIDTH];
                out_empty         <= in_empty[int'(src)*IN_EMPTY_WIDTH +: IN_EMPTY_WIDTH];
                out_port          <= src;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign busy      = (state != S_IDLE) || out_valid;
    assign dbg_state = state;

endmodule

// File: tb/tb_extract_stream_arbiter.sv
module tb_extract_stream_arbiter;

    localparam int NP = 4;
    localparam int DW = 64;
    localparam int EW = 3;
    localparam int W  = 72;  // {port[1:0], sop, eop, err, empty[2:0], data[63:0]}

    logic              clk;
    logic              reset;
    logic [NP-1:0]     in_valid, in_sop, in_eop, in_ready, port_enable;
    logic [NP*DW-1:0]  in_data;
    logic [NP*EW-1:0]  in_empty;
    logic              out_valid, out_sop, out_eop, out_error, out_ready, busy;
    logic [DW-1:0]     out_data;
    logic [EW-1:0]     out_empty;
    logic [1:0]        out_port, dbg_state;
    logic [15:0]       drop_count;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int nbeat  = 0;

    extract_stream_arbiter #(.MAX_BEATS(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_startofpacket(in_sop), .in_endofpacket(in_eop),
        .in_data(in_data), .in_empty(in_empty), .in_ready(in_ready),
        .port_enable(port_enable),
        .out_valid(out_valid), .out_startofpacket(out_sop), .out_endofpacket(out_eop),
        .out_data(out_data), .out_empty(out_empty), .out_error(out_error),
        .out_port(out_port), .out_ready(out_ready),
        .drop_count(drop_count), .busy(busy), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic put_beat(input int p, input logic sop, input logic eop, input logic [DW-1:0] d);
        in_valid[p]         = 1'b1;
        in_sop[p]           = sop;
        in_eop[p]           = eop;
        in_data[p*DW +: DW] = d;
        in_empty[p*EW +: EW] = eop ? 3'd5 : 3'd0;
    endtask

    task automatic drop_beat(input int p);
        in_valid[p] = 1'b0;
        in_sop[p]   = 1'b0;
        in_eop[p]   = 1'b0;
    endtask

    task automatic push(input logic [1:0] p, input logic sop, input logic eop, input logic err,
                        input logic [2:0] emp, input logic [DW-1:0] d);
        exp_q.push_back({p, sop, eop, err, emp, d});
    endtask

    // check the combinational accept vector, then advance one clock
    task automatic cyc(input string tag, input logic [NP-1:0] exp_rdy);
        #1;
        chk({tag, "_rdy"}, W'(in_ready), W'(exp_rdy));
        @(posedge clk);
        #1;
    endtask

    // scoreboard: every beat the extractor takes is matched against exp_q
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("mon_extra_beat", W'(exp_q.size()), W'(1));
            end else begin
                chk($sformatf("beat%0d", nbeat),
                    {out_port, out_sop, out_eop, out_error, out_empty, out_data},
                    exp_q.pop_front());
            end
            nbeat++;
        end
    end

    initial begin
        reset       = 1'b1;
        in_valid    = '0;
        in_sop      = '0;
        in_eop      = '0;
        in_data     = '0;
        in_empty    = '0;
        port_enable = 4'hF;
        out_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_drop", W'(drop_count), W'(0));
        chk("rst_state", W'(dbg_state), W'(0));
        chk("rst_in_ready", W'(in_ready), W'(0));
        chk("rst_out_data", W'(out_data), W'(0));
        chk("rst_out_port", W'(out_port), W'(0));

        // two 3-beat packets, ports 0 and 2, no interleaving
        put_beat(0, 1, 0, 64'hA0); put_beat(2, 1, 0, 64'hC0);
        push(0, 1, 0, 0, 0, 64'hA0);
        cyc("t1_c0", 4'b0001);
        chk("t1_first_valid", W'(out_valid), W'(1));
        chk("t1_first_port", W'(out_port), W'(0));
        put_beat(0, 0, 0, 64'hA1); push(0, 0, 0, 0, 0, 64'hA1);
        cyc("t1_c1", 4'b0001);
        put_beat(0, 0, 1, 64'hA2); push(0, 0, 1, 0, 5, 64'hA2);
        cyc("t1_c2", 4'b0001);
        drop_beat(0); push(2, 1, 0, 0, 0, 64'hC0);
        cyc("t1_c3", 4'b0100);
        put_beat(2, 0, 0, 64'hC1); push(2, 0, 0, 0, 0, 64'hC1);
        cyc("t1_c4", 4'b0100);
        put_beat(2, 0, 1, 64'hC2); push(2, 0, 1, 0, 5, 64'hC2);
        cyc("t1_c5", 4'b0100);
        drop_beat(2);
        cyc("t1_c6", 4'b0000);
        chk("t1_drop", W'(drop_count), W'(0));
        chk("t1_state", W'(dbg_state), W'(0));

        // round robin over single-beat packets, then with port 2 disabled
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int p = 0; p < NP; p++) put_beat(p, 1, 1, 64'hD0 + 64'(p));
        push(0, 1, 1, 0, 5, 64'hD0); cyc("t2_g0", 4'b0001);
        push(1, 1, 1, 0, 5, 64'hD1); cyc("t2_g1", 4'b0010);
        push(2, 1, 1, 0, 5, 64'hD2); cyc("t2_g2", 4'b0100);
        push(3, 1, 1, 0, 5, 64'hD3); cyc("t2_g3", 4'b1000);
        push(0, 1, 1, 0, 5, 64'hD0); cyc("t2_g4", 4'b0001);
        push(1, 1, 1, 0, 5, 64'hD1); cyc("t2_g5", 4'b0010);
        port_enable = 4'b1011;
        push(3, 1, 1, 0, 5, 64'hD3); cyc("t2_e0", 4'b1000);
        push(0, 1, 1, 0, 5, 64'hD0); cyc("t2_e1", 4'b0001);
        push(1, 1, 1, 0, 5, 64'hD1); cyc("t2_e2", 4'b0010);
        push(3, 1, 1, 0, 5, 64'hD3); cyc("t2_e3", 4'b1000);
        for (int p = 0; p < NP; p++) drop_beat(p);
        port_enable = 4'hF;
        cyc("t2_idle", 4'b0000);

        // back-pressure while locked on port 1
        put_beat(1, 1, 0, 64'hB0); push(1, 1, 0, 0, 0, 64'hB0);
        cyc("t3_a", 4'b0010);
        put_beat(1, 0, 0, 64'hB1); out_ready = 1'b0;
        cyc("t3_b", 4'b0000);
        chk("t3_hold_b", W'(out_data), W'(64'hB0));
        cyc("t3_c", 4'b0000);
        chk("t3_hold_c", W'(out_data), W'(64'hB0));
        chk("t3_hold_valid", W'(out_valid), W'(1));
        out_ready = 1'b1; push(1, 0, 0, 0, 0, 64'hB1);
        cyc("t3_d", 4'b0010);
        put_beat(1, 0, 1, 64'hB2); push(1, 0, 1, 0, 5, 64'hB2);
        cyc("t3_e", 4'b0010);
        drop_beat(1);
        cyc("t3_f", 4'b0000);

        // runaway packet on port 0 (limit 4 beats), with a stray mid-packet SOP
        put_beat(0, 1, 0, 64'hE0); push(0, 1, 0, 0, 0, 64'hE0);
        cyc("t4_b1", 4'b0001);
        put_beat(0, 1, 0, 64'hE1); push(0, 0, 0, 1, 0, 64'hE1);
        cyc("t4_b2", 4'b0001);
        put_beat(0, 0, 0, 64'hE2); push(0, 0, 0, 0, 0, 64'hE2);
        cyc("t4_b3", 4'b0001);
        put_beat(0, 0, 0, 64'hE3); push(0, 0, 1, 1, 0, 64'hE3);
        cyc("t4_b4", 4'b0001);
        chk("t4_state_drain", W'(dbg_state), W'(2));
        put_beat(0, 0, 0, 64'hE4);
        cyc("t4_b5", 4'b0001);
        put_beat(0, 0, 1, 64'hE5);
        cyc("t4_b6", 4'b0001);
        chk("t4_drop", W'(drop_count), W'(2));
        chk("t4_state_idle", W'(dbg_state), W'(0));
        drop_beat(0);
        cyc("t4_end", 4'b0000);

        // stray beats on port 3 while port 0 forwards
        put_beat(0, 1, 0, 64'hF0); put_beat(3, 0, 0, 64'h55);
        push(0, 1, 0, 0, 0, 64'hF0);
        cyc("t5_c0", 4'b1001);
        put_beat(0, 0, 0, 64'hF1); push(0, 0, 0, 0, 0, 64'hF1);
        cyc("t5_c1", 4'b1001);
        put_beat(0, 0, 1, 64'hF2); push(0, 0, 1, 0, 5, 64'hF2);
        cyc("t5_c2", 4'b1001);
        drop_beat(0);
        chk("t5_drop", W'(drop_count), W'(5));
        port_enable = 4'b0111;
        cyc("t5_dis", 4'b0000);
        chk("t5_drop_held", W'(drop_count), W'(5));
        drop_beat(3); port_enable = 4'hF;
        cyc("t5_end", 4'b0000);

        // reset in the middle of a port 2 packet
        put_beat(2, 1, 0, 64'h60); push(2, 1, 0, 0, 0, 64'h60);
        cyc("t6_g0", 4'b0100);
        put_beat(2, 0, 0, 64'h61); push(2, 0, 0, 0, 0, 64'h61);
        cyc("t6_g1", 4'b0100);
        put_beat(2, 0, 0, 64'h62); put_beat(1, 1, 1, 64'h71);
        reset = 1'b1;
        cyc("t6_rst", 4'b0000);
        reset = 1'b0;
        drop_beat(2);
        chk("t6_out_valid", W'(out_valid), W'(0));
        chk("t6_busy", W'(busy), W'(0));
        chk("t6_drop", W'(drop_count), W'(0));
        chk("t6_state", W'(dbg_state), W'(0));
        put_beat(2, 1, 1, 64'h63);
        push(1, 1, 1, 0, 5, 64'h71);
        cyc("t6_first", 4'b0010);
        drop_beat(1); push(2, 1, 1, 0, 5, 64'h63);
        cyc("t6_second", 4'b0100);
        drop_beat(2);
        cyc("t6_end", 4'b0000);
        cyc("t6_flush", 4'b0000);
        chk("sb_empty", W'(exp_q.size()), W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
